// File: rtl/fetch_queue_pkg.sv
// Shared widths and helpers for the instruction fetch front end.
package fetch_queue_pkg;

  localparam int FQ_ADDR_LEN = 16;
  localparam int FQ_WORD_LEN = 16;
  localparam int FQ_DEPTH    = 2;

  // Occupancy counters must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries with a single-cycle flush.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers and occupancy; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: credit-limited requests to instruction memory,
// in-order response buffering with PC tags, and redirect flush with stale drop.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                  ADDR_LEN = FQ_ADDR_LEN,
  parameter int                  WORD_LEN = FQ_WORD_LEN,
  parameter int                  DEPTH    = FQ_DEPTH,
  parameter logic [ADDR_LEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req_valid,
  output logic [ADDR_LEN-1:0] imem_req_addr,
  input  logic                imem_req_ready,
  input  logic                imem_rsp_valid,
  input  logic [WORD_LEN-1:0] imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [ADDR_LEN-1:0] redirect_pc,
  output logic                out_valid,
  output logic [WORD_LEN-1:0] out_instr,
  output logic [ADDR_LEN-1:0] out_pc,
  output logic [ADDR_LEN-1:0] out_next_pc,
  input  logic                out_ready
);

  localparam int CW = cnt_width(DEPTH);
  localparam int OW = CW + 1;

  logic [ADDR_LEN-1:0]          fetch_pc, rsp_pc, head_pc;
  logic [CW-1:0]                inflight, drop, count;
  logic [OW-1:0]                occupancy;
  logic [ADDR_LEN+WORD_LEN-1:0] head;
  logic                         empty, full, pop, push, req_fire;

  // A head leaving this cycle frees its slot before any new response can
  // land (earliest one cycle after acceptance), so it is credited here; this
  // is what sustains one instruction per cycle at DEPTH=2.
  assign pop       = reset && !redirect_valid && !empty && out_ready;
  assign occupancy = OW'(count) + OW'(inflight) - OW'(pop);

  assign imem_req_valid = reset && !redirect_valid && (occupancy < OW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses are kept only when no stale ones are still owed.
  assign push = reset && !redirect_valid && imem_rsp_valid && (drop == '0);

  fetch_fifo #(
    .W     (ADDR_LEN + WORD_LEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .din   ({rsp_pc, imem_rsp_data}),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign head_pc     = head[WORD_LEN +: ADDR_LEN];
  assign out_valid   = reset && !empty;
  assign out_pc      = reset ? head_pc : '0;
  assign out_next_pc = reset ? head_pc + 1'b1 : ADDR_LEN'(1);
  assign out_instr   = reset ? head[WORD_LEN-1:0] : '0;

  // Fetch/tag PCs and the outstanding-request bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (redirect_valid) begin
      // Everything still outstanding becomes stale; a response arriving now
      // is one of them and is discarded immediately.
      fetch_pc <= redirect_pc;
      rsp_pc   <= redirect_pc;
      inflight <= '0;
      drop     <= drop + inflight
                  - CW'(imem_rsp_valid && ((drop != '0) || (inflight != '0)));
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 1'b1;
      if (push)     rsp_pc   <= rsp_pc + 1'b1;
      inflight <= inflight + CW'(req_fire) - CW'(push);
      if (imem_rsp_valid && (drop != '0)) drop <= drop - 1'b1;
    end
  end

  // Counter bounds and the no-overflow guarantee of the credit scheme.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (count <= CW'(DEPTH));
      assert (inflight <= CW'(DEPTH));
      assert (drop <= CW'(DEPTH));
      assert (!(push && full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: per-cycle vector table plus redirect,
// wrap-around and long-latency sequences against a fixed-latency memory model.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic [15:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid = 1'b0;
  logic [15:0] imem_rsp_data  = '0;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic [15:0] out_instr, out_pc, out_next_pc;
  logic        out_ready;

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_next_pc(out_next_pc), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] f(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  // Fixed-latency, in-order memory model.
  typedef struct { logic [15:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int    ecnt = 0;
  int    lat  = 1;

  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready)
      mq.push_back('{addr: imem_req_addr, due: ecnt + lat - 1});
    if (mq.size() > 0 && mq[0].due == ecnt) begin
      imem_rsp_valid <= 1'b1;
      imem_rsp_data  <= f(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid <= 1'b0;
    end
    ecnt <= ecnt + 1;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Wait (bounded) for the next valid head and check it; entry and exit at a negedge.
  task automatic collect(input logic [15:0] exp_pc);
    bit          got = 1'b0;
    logic [15:0] nx;
    nx = exp_pc + 16'd1;
    for (int w = 0; w < 30 && !got; w++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        chk($sformatf("collect_pc_%h", exp_pc), out_pc, exp_pc);
        chk($sformatf("collect_next_%h", exp_pc), out_next_pc, nx);
        chk($sformatf("collect_instr_%h", exp_pc), out_instr, f(exp_pc));
      end
      @(negedge clk);
    end
    if (!got) begin
      total_cnt++;
      $display("FAIL collect_timeout: out_valid never rose, expected pc %h", exp_pc);
    end
  endtask

  typedef struct {
    logic        rst, rdy, redir;
    logic [15:0] rpc;
    logic        e_rv;
    logic [15:0] e_ra;
    logic        chk_out, e_ov;
    logic [15:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                              input logic [15:0] rpc, input logic e_rv,
                              input logic [15:0] e_ra, input logic chk_out,
                              input logic e_ov, input logic [15:0] e_pc);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_rv = e_rv; v.e_ra = e_ra; v.chk_out = chk_out; v.e_ov = e_ov; v.e_pc = e_pc;
    return v;
  endfunction

  vec_t vt[25];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Memory always ready, 1-cycle latency. Fields:
    // rst rdy redir rpc | req_valid req_addr | chk_out out_valid out_pc
    vt[0]  = mk(0, 1, 0, 16'h0,  0, 16'h0,  1, 0, 16'h0);
    vt[1]  = mk(1, 1, 0, 16'h0,  1, 16'h0,  1, 0, 16'h0);
    vt[2]  = mk(1, 1, 0, 16'h0,  1, 16'h1,  1, 0, 16'h0);
    vt[3]  = mk(1, 1, 0, 16'h0,  1, 16'h2,  1, 1, 16'h0);
    vt[4]  = mk(1, 1, 0, 16'h0,  1, 16'h3,  1, 1, 16'h1);
    vt[5]  = mk(1, 1, 0, 16'h0,  1, 16'h4,  1, 1, 16'h2);
    vt[6]  = mk(1, 1, 0, 16'h0,  1, 16'h5,  1, 1, 16'h3);
    vt[7]  = mk(1, 0, 0, 16'h0,  0, 16'h0,  1, 1, 16'h4);
    vt[8]  = mk(1, 0, 0, 16'h0,  0, 16'h0,  1, 1, 16'h4);
    vt[9]  = mk(1, 0, 0, 16'h0,  0, 16'h0,  1, 1, 16'h4);
    vt[10] = mk(1, 0, 0, 16'h0,  0, 16'h0,  1, 1, 16'h4);
    vt[11] = mk(1, 0, 0, 16'h0,  0, 16'h0,  1, 1, 16'h4);
    vt[12] = mk(1, 1, 0, 16'h0,  1, 16'h6,  1, 1, 16'h4);
    vt[13] = mk(1, 1, 0, 16'h0,  1, 16'h7,  1, 1, 16'h5);
    vt[14] = mk(1, 1, 0, 16'h0,  1, 16'h8,  1, 1, 16'h6);
    vt[15] = mk(1, 1, 1, 16'h40, 0, 16'h0,  0, 0, 16'h0);
    vt[16] = mk(1, 1, 0, 16'h0,  1, 16'h40, 1, 0, 16'h0);
    vt[17] = mk(1, 1, 0, 16'h0,  1, 16'h41, 1, 0, 16'h0);
    vt[18] = mk(1, 1, 0, 16'h0,  1, 16'h42, 1, 1, 16'h40);
    vt[19] = mk(1, 1, 0, 16'h0,  1, 16'h43, 1, 1, 16'h41);
    vt[20] = mk(0, 1, 0, 16'h0,  0, 16'h0,  1, 0, 16'h0);
    vt[21] = mk(1, 1, 0, 16'h0,  1, 16'h0,  1, 0, 16'h0);
    vt[22] = mk(1, 1, 0, 16'h0,  1, 16'h1,  1, 0, 16'h0);
    vt[23] = mk(1, 1, 0, 16'h0,  1, 16'h2,  1, 1, 16'h0);
    vt[24] = mk(1, 1, 0, 16'h0,  1, 16'h3,  1, 1, 16'h1);

    reset = 1'b0; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; out_ready = 1'b1;

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      reset = vt[i].rst; out_ready = vt[i].rdy;
      redirect_valid = vt[i].redir; redirect_pc = vt[i].rpc;
      #1;
      chk($sformatf("row%0d_req_valid", i), 16'(imem_req_valid), 16'(vt[i].e_rv));
      if (vt[i].e_rv)
        chk($sformatf("row%0d_req_addr", i), imem_req_addr, vt[i].e_ra);
      if (vt[i].chk_out)
        chk($sformatf("row%0d_out_valid", i), 16'(out_valid), 16'(vt[i].e_ov));
      if (vt[i].e_ov) begin
        chk($sformatf("row%0d_out_pc", i), out_pc, vt[i].e_pc);
        chk($sformatf("row%0d_out_next_pc", i), out_next_pc, vt[i].e_pc + 16'd1);
        chk($sformatf("row%0d_out_instr", i), out_instr, f(vt[i].e_pc));
      end
      if (!vt[i].rst) begin
        chk($sformatf("row%0d_rst_pc", i), out_pc, 16'h0000);
        chk($sformatf("row%0d_rst_next_pc", i), out_next_pc, 16'h0001);
        chk($sformatf("row%0d_rst_instr", i), out_instr, 16'h0000);
      end
    end

    // Address wrap: 0xFFFE, 0xFFFF (next 0x0000), then 0x0000.
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    @(negedge clk);
    redirect_valid = 1'b0;
    collect(16'hFFFE);
    collect(16'hFFFF);
    collect(16'h0000);

    // Drain, switch memory to 3-cycle latency, redirect with 2 fetches in flight.
    imem_req_ready = 1'b0;
    repeat (6) @(negedge clk);
    lat = 3;
    imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    #1;
    chk("redir_blocks_req", 16'(imem_req_valid), 16'h0000);
    @(negedge clk);
    redirect_valid = 1'b0;
    collect(16'h0040);
    collect(16'h0041);
    collect(16'h0042);

    // Back-to-back redirects with stale fetches still pending.
    imem_req_ready = 1'b0;
    repeat (6) @(negedge clk);
    imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0010;
    @(negedge clk);
    redirect_pc = 16'h0020;
    @(negedge clk);
    redirect_valid = 1'b0;
    collect(16'h0020);
    collect(16'h0021);
    collect(16'h0022);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
